// File: rtl/uart_tx_tick.sv
// UART transmitter driven by a 16x oversampling tick.
// Sends one frame per accepted word: start bit, DBIT data bits (LSB first),
// then a stop period of SB_TICK ticks on a registered, idle-high line.
//
// Handshake: the producer raises tx_start with din valid. The word is accepted
// on the first rising edge where the FSM is in IDLE (busy low, which includes
// the cycle carrying tx_done_tick). busy is high from the accepting edge
// until the edge that returns to IDLE. tx_start and din are ignored while
// busy is high.
module uart_tx_tick #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    // Tick counter is wide enough for the stop period, but never below 4 bits.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_LAST    = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; the line value is derived from the next state so the
    // registered tx always matches the state it sits beside.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done_next  = 1'b0;
        tx_next    = 1'b1;

        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    b_next     = din;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        s_next     = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign busy         = (state_reg != IDLE);
    assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: an 8N1 instance and a DBIT=7/SB_TICK=32
// instance share clock, reset and tick; frames are checked cycle by cycle.
module tb_uart_tx_tick;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start8, tx_start7;
    logic [7:0] din8;
    logic [6:0] din7;
    logic       tx8, busy8, done8;
    logic       tx7, busy7, done7;

    int checks;
    int failures;

    uart_tx_tick #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start8),
        .din          (din8),
        .tx           (tx8),
        .busy         (busy8),
        .tx_done_tick (done8)
    );

    uart_tx_tick #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start7),
        .din          (din7),
        .tx           (tx7),
        .busy         (busy7),
        .tx_done_tick (done7)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame description: seq holds the data bits in line order.
    typedef struct {
        string      name;
        int         dut;
        logic [8:0] din;
        int         period;
        logic [0:9] seq;
        int         nbits;
        int         stop_ticks;
        int         stall_at;
        int         stall_len;
        int         exp_len;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] outs(input int dut);
        return (dut == 0) ? {tx8, busy8, done8} : {tx7, busy7, done7};
    endfunction

    function automatic logic exp_line(input vec_t v, input int t);
        if (t < 16) return 1'b0;
        if (t < 16 + 16 * v.nbits) return v.seq[(t - 16) / 16];
        return 1'b1;
    endfunction

    // Driver tasks
    task automatic drive_start(input int dut, input logic st, input logic [8:0] d);
        if (dut == 0) begin
            tx_start8 = st;
            din8      = d[7:0];
        end else begin
            tx_start7 = st;
            din7      = d[6:0];
        end
    endtask

    task automatic idle_cycles(input string name, input int n);
        tx_start8 = 1'b0;
        tx_start7 = 1'b0;
        s_tick    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_idle_tx8", name), 32'(tx8), 32'd1);
            check($sformatf("%s_idle_busy8", name), 32'(busy8), 32'd0);
            check($sformatf("%s_idle_done8", name), 32'(done8), 32'd0);
            check($sformatf("%s_idle_tx7", name), 32'(tx7), 32'd1);
            check($sformatf("%s_idle_busy7", name), 32'(busy7), 32'd0);
            check($sformatf("%s_idle_done7", name), 32'(done7), 32'd0);
        end
    endtask

    // Caller sits at a negedge with the DUT idle. Request goes up for the
    // accepting edge; afterwards din is scrambled (or set to next_din when
    // tx_start is kept high for a back-to-back frame). Returns right after
    // checking the tx_done_tick cycle.
    task automatic run_frame(input vec_t v, input logic keep_start, input logic [8:0] next_din);
        int t;
        logic [2:0] o;
        t = 0;
        drive_start(v.dut, 1'b1, v.din);
        s_tick = 1'b0;
        for (int j = 1; j <= v.exp_len + 1; j++) begin
            @(negedge clk);
            if (j == 1) drive_start(v.dut, keep_start, keep_start ? next_din : ~v.din);
            o = outs(v.dut);
            if (j <= v.exp_len) begin
                check($sformatf("%s_tx@%0d", v.name, j), 32'(o[2]), 32'(exp_line(v, t)));
                check($sformatf("%s_busy@%0d", v.name, j), 32'(o[1]), 32'd1);
                check($sformatf("%s_done@%0d", v.name, j), 32'(o[0]), 32'd0);
            end else begin
                check($sformatf("%s_end_tx", v.name), 32'(o[2]), 32'd1);
                check($sformatf("%s_end_busy", v.name), 32'(o[1]), 32'd0);
                check($sformatf("%s_end_done", v.name), 32'(o[0]), 32'd1);
            end
            if (j >= v.stall_at && j < v.stall_at + v.stall_len)
                s_tick = 1'b0;
            else if (j >= v.stall_at + v.stall_len)
                s_tick = ((j - v.stall_len) % v.period) == 0;
            else
                s_tick = (j % v.period) == 0;
            if (s_tick) t++;
        end
    endtask

    initial begin
        vec_t v;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        s_tick    = 1'b0;
        tx_start8 = 1'b0;
        tx_start7 = 1'b0;
        din8      = '0;
        din7      = '0;

        vecs[0] = '{"a5_tick_hi",  0, 9'h0A5, 1, 10'b1010010100, 8, 16, 0,   0, 160};
        vecs[1] = '{"3c_baud5",    0, 9'h03C, 5, 10'b0011110000, 8, 16, 0,   0, 800};
        vecs[2] = '{"c3_stall",    0, 9'h0C3, 1, 10'b1100001100, 8, 16, 6, 200, 360};
        vecs[3] = '{"2d_dbit7",    1, 9'h02D, 1, 10'b1011010000, 7, 32, 0,   0, 160};

        // Reset held three cycles with tx_start high on both: must stay idle
        tx_start8 = 1'b1;
        tx_start7 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx8", 32'(tx8), 32'd1);
            check("rst_busy8", 32'(busy8), 32'd0);
            check("rst_done8", 32'(done8), 32'd0);
            check("rst_tx7", 32'(tx7), 32'd1);
            check("rst_busy7", 32'(busy7), 32'd0);
        end
        reset = 1'b0;
        idle_cycles("post_rst", 20);

        // Table-driven frames
        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k], 1'b0, 9'h000);
            idle_cycles(vecs[k].name, 3);
        end

        // Back-to-back: tx_start held, din switched after first acceptance
        v = '{"b2b_01", 0, 9'h001, 1, 10'b1000000000, 8, 16, 0, 0, 160};
        run_frame(v, 1'b1, 9'h0FF);
        v = '{"b2b_ff", 0, 9'h0FF, 1, 10'b1111111100, 8, 16, 0, 0, 160};
        run_frame(v, 1'b0, 9'h000);
        idle_cycles("b2b", 3);

        // Mid-frame reset in DATA (bit 2 of 8'h5A is 0)
        drive_start(0, 1'b1, 9'h05A);
        s_tick = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j == 1) drive_start(0, 1'b0, 9'h0A5);
            check($sformatf("mid_busy@%0d", j), 32'(busy8), 32'd1);
            check($sformatf("mid_done@%0d", j), 32'(done8), 32'd0);
        end
        check("mid_tx_before_rst", 32'(tx8), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx8), 32'd1);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        reset = 1'b0;
        idle_cycles("mid_rst", 20);
        v = '{"after_rst_55", 0, 9'h055, 1, 10'b1010101000, 8, 16, 0, 0, 160};
        run_frame(v, 1'b0, 9'h000);
        idle_cycles("after_rst", 3);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial UART transmitter that consumes the one-cycle `done` tick of the team's parameterised modulus timer, used as a 16x oversampling baud tick.
- Frames a parallel word as start bit, DBIT data bits (LSB first) and a stop period, then drives them onto a single line.
- Sits directly downstream of the baud timer and upstream of the board TX pin; a producer (FIFO or FSM) hands it words through a start/done handshake.

Parameters:
- DBIT, 8, number of data bits per frame (legal range 5..9).
- SB_TICK, 16, stop-period length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tick  input  1  oversampling tick from the baud timer `done`; one clk wide, 16 per bit period.
- tx_start  input  1  request to send din; sampled only in IDLE.
- din  input  DBIT  data word; captured on the accepting edge.
- tx  output  1  serial line, registered, idle-high.
- busy  output  1  high whenever state != IDLE.
- tx_done_tick  output  1  one-clk pulse at frame completion.

Behaviour:
- Reset (sync, reset=1 at an edge): state=IDLE, tx=1, busy=0, tx_done_tick=0, s_cnt=0, n_cnt=0, shift reg=0. Reset overrides everything, including mid-frame. The partial frame is abandoned with no tx_done_tick, and tx=1 from the next edge.
- Internal registers:
  - s_cnt is 4 bits and counts s_tick within a bit. For the stop period it is widened to $clog2(SB_TICK) bits, minimum 4.
  - n_cnt is $clog2(DBIT) bits and counts data bits.
  - b_reg is DBIT bits and holds the data being shifted out.
- tx is a register loaded with the line value of the next state, so tx always equals the value for the current state. There is no combinational path from inputs to tx.
- IDLE: tx=1.
  - Edge with tx_start=1: b_reg<=din, s_cnt<=0, state<=START. tx goes 0 on that same edge.
  - tx_start is ignored in every other state; din is not re-sampled.
- START: tx=0.
  - Each edge with s_tick=1: s_cnt<=s_cnt+1.
  - At s_tick with s_cnt==15: s_cnt<=0, n_cnt<=0, state<=DATA.
- DATA: tx=b_reg[0].
  - At s_tick with s_cnt==15: s_cnt<=0, b_reg<=b_reg>>1.
  - If n_cnt==DBIT-1 then state<=STOP, else n_cnt<=n_cnt+1.
- STOP: tx=1.
  - At s_tick with s_cnt==SB_TICK-1: state<=IDLE, tx_done_tick<=1 for exactly one clk.
- tx_done_tick is registered and coincides with the first IDLE cycle. A tx_start in that same cycle is accepted, giving back-to-back frames with no extra idle gap.
- s_tick low: all counters and tx hold. The frame stalls indefinitely, with no timeout.
- Frame length is 16 + 16·DBIT + SB_TICK s_tick pulses: 160 for 8N1 with SB_TICK=16.
- Counters wrap only by explicit clear; no free-running wrap.
- busy=1 from the edge that accepts tx_start through the edge that returns to IDLE.
- din changes while busy have no effect on the frame in flight.

Test Plan:
- Reset/idle: assert reset 3 cycles, then release with tx_start=0 for 20 cycles -> tx=1, busy=0, tx_done_tick=0 throughout.
- Single frame, s_tick tied high, din=8'hA5, one-cycle tx_start:
  - tx=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles.
  - tx_done_tick high exactly once, 160 cycles after acceptance; busy low on the same edge.
- Realistic tick: s_tick from the baud timer with Final_value=4 (tick every 5 clk), din=8'h3C.
  - Each bit lasts 80 clk and the frame lasts 800 clk.
  - Decoded bits are 0,0,1,1,1,1,0,0.
- Back-to-back: hold tx_start=1 continuously with din=8'h01 then 8'hFF (switch after first acceptance).
  - Two frames with no idle-high gap beyond the stop period.
  - tx_done_tick pulses twice; the second frame carries 8'hFF despite the din change during frame 1.
- Mid-frame reset: with s_tick high, pulse reset at cycle 50 of a frame (in DATA).
  - tx=1 and busy=0 from the next edge; no tx_done_tick.
  - A new tx_start with din=8'h55 then yields a clean 160-cycle frame.
- Stall and parameters:
  - Hold s_tick=0 for 200 cycles inside START -> tx stays 0 and the frame resumes afterward.
  - Rerun with DBIT=7, SB_TICK=32 -> frame of 16+112+32=160 ticks with a 32-tick stop period.
